sand_update_controller: RTL and testbench

// Sequences one falling-sand physics pass over the cell framebuffer (register_file: 1 write port,

---
 rtl/sand_pkg.sv | 17 +
 rtl/grid_scan_counter.sv | 50 +++++
 rtl/sand_update_controller.sv | 167 ++++++++++++++++
 tb/tb_sand_update_controller.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sand_pkg.sv
// Shared types for the falling-sand update sequencer.
package sand_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CUR   = 3'd1,
    BELOW = 3'd2,
    D1    = 3'd3,
    D2    = 3'd4,
    WDST  = 3'd5,
    WSRC  = 3'd6,
    DONE  = 3'd7
  } state_t;

  localparam logic CELL_EMPTY = 1'b0;

endpackage

// File: rtl/grid_scan_counter.sv
// Bottom-up raster counter over the source rows; wraps back to the first source cell
// after the last one so the next pass always starts at (0, V_RES-2).
module grid_scan_counter
  import sand_pkg::*;
#(
  parameter int H_RES      = 4,
  parameter int V_RES      = 4,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  advance_i,
  output logic [ADDR_WIDTH-1:0] x_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  last_o
);

  localparam logic [ADDR_WIDTH-1:0] X_LAST = ADDR_WIDTH'(H_RES - 1);
  localparam logic [ADDR_WIDTH-1:0] Y_TOP  = ADDR_WIDTH'(V_RES - 2);
  localparam logic [ADDR_WIDTH-1:0] H_W    = ADDR_WIDTH'(H_RES);
  localparam logic [ADDR_WIDTH-1:0] ONE    = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] r_x;
  logic [ADDR_WIDTH-1:0] r_y;
  logic                  w_last;

  assign w_last = (r_x == X_LAST) && (r_y == '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_x <= '0;
      r_y <= Y_TOP;
    end else if (advance_i) begin
      if (w_last) begin
        r_x <= '0;
        r_y <= Y_TOP;
      end else if (r_x == X_LAST) begin
        r_x <= '0;
        r_y <= r_y - ONE;
      end else begin
        r_x <= r_x + ONE;
      end
    end
  end

  assign x_o    = r_x;
  assign addr_o = r_y * H_W + r_x;
  assign last_o = w_last;

endmodule

// File: rtl/sand_update_controller.sv
// One falling-sand pass over the framebuffer: probe below, then both diagonals,
// and move each grain with a write-destination / clear-source pair.
module sand_update_controller
  import sand_pkg::*;
#(
  parameter int H_RES      = 4,
  parameter int V_RES      = 4,
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [ADDR_WIDTH-1:0] read_address_o,
  input  logic [DATA_WIDTH-1:0] read_data_i,
  output logic                  write_en_o,
  output logic [ADDR_WIDTH-1:0] write_address_o,
  output logic [DATA_WIDTH-1:0] write_data_o
);

  localparam logic [ADDR_WIDTH-1:0] X_LAST = ADDR_WIDTH'(H_RES - 1);
  localparam logic [ADDR_WIDTH-1:0] H_W    = ADDR_WIDTH'(H_RES);
  localparam logic [ADDR_WIDTH-1:0] ONE    = ADDR_WIDTH'(1);

  state_t                r_state;
  state_t                w_next_state;
  logic [DATA_WIDTH-1:0] r_cell;
  logic [ADDR_WIDTH-1:0] r_dst;
  logic                  r_dir;

  logic [ADDR_WIDTH-1:0] w_x;
  logic [ADDR_WIDTH-1:0] w_src;
  logic                  w_last;
  logic                  w_advance;
  logic                  w_load_cell;
  logic                  w_capture_dst;
  logic [ADDR_WIDTH-1:0] w_below;
  logic [ADDR_WIDTH-1:0] w_pref_addr;
  logic [ADDR_WIDTH-1:0] w_oth_addr;
  logic                  w_pref_ok;
  logic                  w_oth_ok;
  logic                  w_rd_empty;

  grid_scan_counter #(
    .H_RES      (H_RES),
    .V_RES      (V_RES),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_scan (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .advance_i (w_advance),
    .x_o       (w_x),
    .addr_o    (w_src),
    .last_o    (w_last)
  );

  // Off-grid diagonals count as full; with H_RES=1 both sides are off-grid.
  assign w_below     = w_src + H_W;
  assign w_pref_ok   = r_dir ? (w_x != X_LAST) : (w_x != '0);
  assign w_oth_ok    = r_dir ? (w_x != '0) : (w_x != X_LAST);
  assign w_pref_addr = r_dir ? (w_below + ONE) : (w_below - ONE);
  assign w_oth_addr  = r_dir ? (w_below - ONE) : (w_below + ONE);
  assign w_rd_empty  = (read_data_i == {DATA_WIDTH{CELL_EMPTY}});

  always_comb begin
    w_next_state    = r_state;
    w_advance       = 1'b0;
    w_load_cell     = 1'b0;
    w_capture_dst   = 1'b0;
    busy_o          = 1'b1;
    done_o          = 1'b0;
    read_address_o  = '0;
    write_en_o      = 1'b0;
    write_address_o = '0;
    write_data_o    = '0;
    case (r_state)
      IDLE: begin
        busy_o       = 1'b0;
        w_next_state = start_i ? CUR : IDLE;
      end
      CUR: begin
        read_address_o = w_src;
        w_advance      = w_rd_empty;
        w_load_cell    = ~w_rd_empty;
        w_next_state   = BELOW;
      end
      BELOW: begin
        read_address_o = w_below;
        w_capture_dst  = w_rd_empty;
        w_next_state   = w_rd_empty ? WDST : D1;
      end
      D1: begin
        // A skipped preferred side collapses D1 and D2 into this cycle.
        if (w_pref_ok) begin
          read_address_o = w_pref_addr;
          w_capture_dst  = w_rd_empty;
          w_next_state   = w_rd_empty ? WDST : D2;
        end else if (w_oth_ok) begin
          read_address_o = w_oth_addr;
          w_capture_dst  = w_rd_empty;
          w_advance      = ~w_rd_empty;
          w_next_state   = WDST;
        end else begin
          w_advance = 1'b1;
        end
      end
      D2: begin
        if (w_oth_ok) begin
          read_address_o = w_oth_addr;
          w_capture_dst  = w_rd_empty;
          w_advance      = ~w_rd_empty;
          w_next_state   = WDST;
        end else begin
          w_advance = 1'b1;
        end
      end
      WDST: begin
        write_en_o      = 1'b1;
        write_address_o = r_dst;
        write_data_o    = r_cell;
        w_next_state    = WSRC;
      end
      WSRC: begin
        write_en_o      = 1'b1;
        write_address_o = w_src;
        w_advance       = 1'b1;
      end
      DONE: begin
        busy_o       = 1'b0;
        done_o       = 1'b1;
        w_next_state = IDLE;
      end
      default: begin
        busy_o       = 1'b0;
        w_next_state = IDLE;
      end
    endcase
    if (w_advance) begin
      w_next_state = w_last ? DONE : CUR;
    end else begin
      w_next_state = w_next_state;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_cell  <= '0;
      r_dst   <= '0;
      r_dir   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_load_cell) begin
        r_cell <= read_data_i;
      end
      if (w_capture_dst) begin
        r_dst <= read_address_o;
      end
      if (r_state == DONE) begin
        r_dir <= ~r_dir;
      end
    end
  end

endmodule

// File: tb/tb_sand_update_controller.sv
// Self-checking bench: a cell-level model builds the expected per-cycle port trace of each
// pass, and a single negedge process compares the DUT against it.
module tb_sand_update_controller;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic [3:0] ra;
    logic       we;
    logic [3:0] wa;
    logic       wd;
  } rec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       busy, done, we, wd;
  logic [3:0] ra, wa;
  logic       rd;

  logic [15:0] fb = 16'h0000;
  logic [15:0] load_img = 16'h0000;
  logic        load_go = 1'b0;
  logic [15:0] cur_img = 16'h0000;
  logic [15:0] exp_img = 16'h0000;
  logic        model_dir = 1'b0;
  rec_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          bc;

  sand_update_controller #(
    .H_RES(4), .V_RES(4), .ADDR_WIDTH(4), .DATA_WIDTH(1)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .start_i         (start),
    .busy_o          (busy),
    .done_o          (done),
    .read_address_o  (ra),
    .read_data_i     (rd),
    .write_en_o      (we),
    .write_address_o (wa),
    .write_data_o    (wd)
  );

  always #5 clk = ~clk;

  assign rd = fb[ra];

  always @(posedge clk) begin
    if (load_go) fb <= load_img;
    else if (we) fb[wa] <= wd;
  end

  function automatic rec_t mk(input logic b, input logic d, input int r, input logic w,
                              input int a, input logic v);
    rec_t x;
    x.busy = b; x.done = d; x.ra = 4'(r); x.we = w; x.wa = 4'(a); x.wd = v;
    return x;
  endfunction

  // Cell-by-cell pass in scan order; memory is updated as grains move so later cells see them.
  task automatic build_expected(input logic [15:0] img, output logic [15:0] fin);
    logic [15:0] m;
    int s, b, dst, pref, oth;
    m = img;
    for (int y = 2; y >= 0; y--) begin
      for (int x = 0; x < 4; x++) begin
        s = y * 4 + x;
        exp_q.push_back(mk(1'b1, 1'b0, s, 1'b0, 0, 1'b0));
        if (m[s]) begin
          b = s + 4;
          dst = -1;
          exp_q.push_back(mk(1'b1, 1'b0, b, 1'b0, 0, 1'b0));
          if (!m[b]) dst = b;
          else begin
            pref = model_dir ? ((x < 3) ? b + 1 : -1) : ((x > 0) ? b - 1 : -1);
            oth  = model_dir ? ((x > 0) ? b - 1 : -1) : ((x < 3) ? b + 1 : -1);
            if (pref >= 0) begin
              exp_q.push_back(mk(1'b1, 1'b0, pref, 1'b0, 0, 1'b0));
              if (!m[pref]) dst = pref;
              else begin
                exp_q.push_back(mk(1'b1, 1'b0, (oth >= 0) ? oth : 0, 1'b0, 0, 1'b0));
                if (oth >= 0 && !m[oth]) dst = oth;
              end
            end else begin
              exp_q.push_back(mk(1'b1, 1'b0, oth, 1'b0, 0, 1'b0));
              if (!m[oth]) dst = oth;
            end
          end
          if (dst >= 0) begin
            exp_q.push_back(mk(1'b1, 1'b0, 0, 1'b1, dst, 1'b1));
            exp_q.push_back(mk(1'b1, 1'b0, 0, 1'b1, s, 1'b0));
            m[dst] = 1'b1;
            m[s] = 1'b0;
          end
        end
      end
    end
    exp_q.push_back(mk(1'b0, 1'b1, 0, 1'b0, 0, 1'b0));
    fin = m;
    model_dir = ~model_dir;
  endtask

  // Per-cycle trace compare; an empty queue means the DUT must sit idle with all outputs 0.
  always @(negedge clk) begin
    rec_t e, a;
    if (!rst) begin
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else e = '0;
      a = {busy, done, ra, we, wa, wd};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL trace t=%0t got b=%b d=%b ra=%0d we=%b wa=%0d wd=%b exp b=%b d=%b ra=%0d we=%b wa=%0d wd=%b",
                 $time, a.busy, a.done, a.ra, a.we, a.wa, a.wd,
                 e.busy, e.done, e.ra, e.we, e.wa, e.wd);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic load(input logic [15:0] v);
    @(posedge clk); #2 load_img = v; load_go = 1'b1;
    @(posedge clk); #2 load_go = 1'b0;
    cur_img = v;
  endtask

  task automatic do_reset();
    @(posedge clk); #2 rst = 1'b1;
    exp_q.delete();
    model_dir = 1'b0;
    @(posedge clk); @(posedge clk); #2 rst = 1'b0;
  endtask

  task automatic start_pass();
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    build_expected(cur_img, exp_img);
  endtask

  task automatic finish_pass(input string nm, input logic pulse, output int busy_cnt);
    logic ok;
    busy_cnt = 0;
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (busy) busy_cnt++;
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #2 start = pulse && (i == 4);
    end
    start = 1'b0;
    chk({nm, " timeout"}, 32'(ok), 32'd1);
    if (!ok) exp_q.delete();
    chk({nm, " image"}, 32'(fb), 32'(exp_img));
    cur_img = exp_img;
  endtask

  task automatic first_write_pair(input string nm, input int a0, input int a1);
    int k;
    k = -1;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (exp_q[i].we && k < 0) k = i;
    end
    chk({nm, " model has write"}, 32'(k >= 0), 32'd1);
    if (k >= 0 && k + 1 < exp_q.size()) begin
      chk({nm, " model write dst"}, 32'(exp_q[k].wa), 32'(a0));
      chk({nm, " model write src"}, 32'(exp_q[k+1].wa), 32'(a1));
    end
  endtask

  initial begin
    logic found;
    int nwr;
    #1;
    chk("reset outputs", 32'({busy, done, ra, we, wa, wd}), 32'd0);
    @(posedge clk); #2 rst = 1'b0;

    load(16'h0002);
    start_pass();
    finish_pass("t1", 1'b0, bc);
    chk("t1 one row only", 32'(fb), 32'h0020);

    do_reset();
    load(16'h2200);
    start_pass();
    first_write_pair("t2", 12, 9);
    finish_pass("t2", 1'b0, bc);
    chk("t2 below-left", 32'(fb), 32'h3000);

    do_reset();
    load(16'h1100);
    start_pass();
    first_write_pair("t3", 13, 8);
    finish_pass("t3", 1'b0, bc);
    chk("t3 left edge skip", 32'(fb), 32'h3000);

    do_reset();
    load(16'h7200);
    start_pass();
    nwr = 0;
    foreach (exp_q[i]) if (exp_q[i].we) nwr++;
    chk("t4 model no writes", 32'(nwr), 32'd0);
    finish_pass("t4", 1'b0, bc);
    chk("t4 blocked", 32'(fb), 32'h7200);

    do_reset();
    load(16'h0000);
    start_pass();
    finish_pass("t5", 1'b1, bc);
    chk("t5 busy cycles", 32'(bc), 32'd12);
    repeat (5) @(posedge clk);
    #2 chk("t5 no second pass", 32'(busy), 32'd0);
    load(16'h2200);
    start_pass();
    first_write_pair("t5b", 14, 9);
    finish_pass("t5b", 1'b0, bc);
    chk("t5 right first", 32'(fb), 32'h6000);

    do_reset();
    load(16'h2200);
    start_pass();
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (we) begin
        found = 1'b1;
        break;
      end
    end
    chk("t6 reached write", 32'(found), 32'd1);
    #1 rst = 1'b1;
    exp_q.delete();
    model_dir = 1'b0;
    #1;
    chk("t6 we after rst", 32'(we), 32'd0);
    chk("t6 busy after rst", 32'(busy), 32'd0);
    @(posedge clk); @(posedge clk); #2 rst = 1'b0;
    chk("t6 memory intact", 32'(fb), 32'h2200);
    start_pass();
    chk("t6 restart addr", 32'(ra), 32'd8);
    finish_pass("t6", 1'b0, bc);
    chk("t6 final", 32'(fb), 32'h3000);

    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(3) == 0) do_reset();
      load(16'($urandom));
      start_pass();
      finish_pass("rand", 1'($urandom_range(1)), bc);
    end

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
